hbif_cmd_engine: RTL and testbench
==================================

// Module: hbif_cmd_engine
// PURPOSE
// - Host-side command engine for the UART host bus interface: consumes bytes from the UART receiver,
//   decodes read/write frames, runs one register-bus transaction per frame, returns a response byte.
// - Sits between the uart RX byte port (valid-only, no backpressure) and TX byte port (valid/ready),
//   replacing the RX->TX loopback; on the far side it drives the internal register bus.
// PARAMETERS
// - ADDR_W        8      register-bus address width (1..8); address byte truncated to ADDR_W LSBs
// - TIMEOUT_CLKS  65536  idle clocks allowed between bytes of one frame before the frame is dropped
// - ACK_BYTE      8'h06  response to a completed write
// - NAK_BYTE      8'h15  response to a bad command byte (or bad checksum when enabled)
// PORTS
// - clk_i          in   1       clock
// - rst_i          in   1       synchronous reset, active-high
// - en_i           in   1       0: engine held in IDLE, incoming bytes ignored
// - rx_valid_i     in   1       one-cycle pulse: rx_data_i holds a received byte
// - rx_data_i      in   8       received byte
// - tx_valid_o     out  1       response byte valid
// - tx_data_o      out  8       response byte
// - tx_ready_i     in   1       transmitter accepts byte when tx_valid_o & tx_ready_i
// - bus_req_o      out  1       bus request, held until bus_gnt_i
// - bus_we_o       out  1       1 write, 0 read; stable while bus_req_o
// - bus_addr_o     out  ADDR_W  address; stable while bus_req_o
// - bus_wdata_o    out  8       write data; stable while bus_req_o
// - bus_gnt_i      in   1       request accepted; a write completes on this cycle
// - bus_rvalid_i   in   1       read data valid; same cycle as bus_gnt_i or any later cycle
// - bus_rdata_i    in   8       read data
// - overrun_o      out  1       sticky: byte arrived while engine busy (BUS/RESP); cleared by reset only
// BEHAVIOUR
// - Reset: clk_i edge with rst_i=1 -> state IDLE; all outputs 0; timeout counter 0; capture regs 0.
//   Reset mid-frame or mid-bus-op aborts immediately; no response sent; bus_req_o drops next cycle.
// - Frames: write = 'W'(8'h57), ADDR, DATA; read = 'R'(8'h52), ADDR. Any other first byte -> NAK.
// - FSM: IDLE -rx W/R-> ADDR; IDLE -rx other-> RESP(NAK). ADDR -rx-> DATA (write) | BUS (read).
//   DATA -rx-> BUS. BUS: bus_req_o=1 from the cycle after the last byte; write: on gnt -> RESP(ACK);
//   read: on gnt -> RWAIT (or -> RESP(rdata) if bus_rvalid_i same cycle); RWAIT -rvalid-> RESP(rdata).
//   RESP: tx_valid_o=1, tx_data_o stable until tx_ready_i; on handshake -> IDLE.
// - Latency: last frame byte at cycle N -> bus_req_o at N+1; gnt/rvalid at M -> tx_valid_o at M+1.
// - Response data captured into a register; bus_rdata_i sampled only when bus_rvalid_i=1.
// - Timeout: counter clears on every rx_valid_i, counts in ADDR/DATA(/CSUM); at TIMEOUT_CLKS -> IDLE,
//   frame discarded silently, no bus op. Counter saturates; not active in IDLE/BUS/RWAIT/RESP.
// - Bytes during BUS/RWAIT/RESP are dropped and set overrun_o; the transaction is unaffected.
// - Byte in the same cycle as RESP handshake is dropped (overrun) -- engine is IDLE only from next cycle.
// - en_i=0: IDLE/ADDR/DATA(/CSUM) forced to IDLE; an in-flight BUS/RWAIT/RESP completes normally.
// - No bus errors; a bus that never grants stalls the engine (only rst_i recovers).
// CONFIGURATION
// - Macro HBIF_CHECKSUM_EN defined: each frame carries one extra trailing byte = XOR of all prior frame
//   bytes; state CSUM follows ADDR (read) / DATA (write); mismatch -> RESP(NAK), no bus op.
//   Bad command byte still NAKs at once (no checksum consumed).
// - Undefined: no CSUM state; frames exactly as above; XOR logic absent.
// TESTING
// - Write: rx 57,10,A5 -> bus_req/we=1,addr=10,wdata=A5; gnt after 3 clks -> tx 06 once, back to IDLE.
// - Read: rx 52,3C; gnt cycle 0, rvalid+rdata=C3 4 clks later -> tx C3; tx_ready low 10 clks, data held.
// - Bad cmd: rx 41 -> tx 15 next cycle, no bus_req; then rx 52,01 works normally.
// - Timeout (TIMEOUT_CLKS=16): rx 57,20 then 16 idle clks, then 52,20 -> single read of 20, no write.
// - Overrun/reset: rx 57,01,02 then rx FF during BUS -> overrun_o=1, ACK still sent; rst_i in RWAIT
//   -> all outputs 0 next cycle, no tx.
// - HBIF_CHECKSUM_EN: rx 57,10,A5,E2 -> write+ACK; rx 57,10,A5,00 -> tx 15, no bus_req.

Source files
------------

// File: rtl/hbif_cmd_engine.sv
// Host command engine: parses UART read/write frames, runs one register-bus op per frame, replies one byte.
// Optional trailing XOR checksum byte per frame when HBIF_CHECKSUM_EN is defined.
module hbif_cmd_engine #(
    parameter int          ADDR_W       = 8,
    parameter int          TIMEOUT_CLKS = 65536,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_ready_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [7:0]        bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [7:0]        bus_rdata_i,
    output logic              overrun_o
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam int         CNT_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CSUM, S_BUS, S_RWAIT, S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         resp_q, resp_d;
    logic               ovr_q, ovr_d;
`ifdef HBIF_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic busy;
    logic frame_st;

    assign busy     = (state_q == S_BUS) || (state_q == S_RWAIT) || (state_q == S_RESP);
    assign frame_st = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CSUM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            ovr_q   <= 1'b0;
`ifdef HBIF_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            ovr_q   <= ovr_d;
`ifdef HBIF_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        ovr_d   = ovr_q | (rx_valid_i & busy);
`ifdef HBIF_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en_i && rx_valid_i) begin
`ifdef HBIF_CHECKSUM_EN
                    csum_d = rx_data_i;
`endif
                    if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
                        we_d    = (rx_data_i == CMD_WRITE);
                        state_d = S_ADDR;
                    end else begin
                        resp_d  = NAK_BYTE;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid_i) begin
                    addr_d = rx_data_i[ADDR_W-1:0];
`ifdef HBIF_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data_i;
                    state_d = we_q ? S_DATA : S_CSUM;
`else
                    state_d = we_q ? S_DATA : S_BUS;
`endif
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    wdata_d = rx_data_i;
`ifdef HBIF_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data_i;
                    state_d = S_CSUM;
`else
                    state_d = S_BUS;
`endif
                end
            end
            S_CSUM: begin
`ifdef HBIF_CHECKSUM_EN
                if (rx_valid_i) begin
                    if (rx_data_i == csum_q) begin
                        state_d = S_BUS;
                    end else begin
                        resp_d  = NAK_BYTE;
                        state_d = S_RESP;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_BUS: begin
                if (bus_gnt_i) begin
                    if (we_q) begin
                        resp_d  = ACK_BYTE;
                        state_d = S_RESP;
                    end else if (bus_rvalid_i) begin
                        resp_d  = bus_rdata_i;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_RWAIT;
                    end
                end
            end
            S_RWAIT: begin
                if (bus_rvalid_i) begin
                    resp_d  = bus_rdata_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame collection: disable aborts, inter-byte silence longer than the limit drops the frame
        if (frame_st) begin
            if (!en_i) begin
                state_d = S_IDLE;
            end else if (!rx_valid_i) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_q >= CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_comb begin
        tx_valid_o = (state_q == S_RESP);
        bus_req_o  = (state_q == S_BUS);
    end

    assign tx_data_o   = resp_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_hbif_cmd_engine.sv
// Bench for hbif_cmd_engine: frame-level reference model checked every cycle, directed scenarios, random traffic.
module tb_hbif_cmd_engine;

    localparam int AW = 6;
    localparam int TO = 16;
`ifdef HBIF_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i = 1'b1;
    logic          rx_valid_i = 1'b0;
    logic [7:0]    rx_data_i = 8'h00;
    logic          tx_valid_o;
    logic [7:0]    tx_data_o;
    logic          tx_ready_i = 1'b0;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [AW-1:0] bus_addr_o;
    logic [7:0]    bus_wdata_o;
    logic          bus_gnt_i = 1'b0;
    logic          bus_rvalid_i = 1'b0;
    logic [7:0]    bus_rdata_i = 8'h00;
    logic          overrun_o;

    hbif_cmd_engine #(.ADDR_W(AW), .TIMEOUT_CLKS(TO), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit man = 1'b1;

    // Reference model: pending frame bytes, one outstanding bus op, one pending reply
    logic [7:0] m_frame[$];
    int         m_idle = 0;
    bit         m_op = 0, m_we = 0, m_granted = 0, m_reply = 0, m_ovr = 0, m_rst_seen = 0;
    logic [7:0] m_addr = 0, m_wdata = 0, m_reply_byte = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reply(input logic [7:0] b);
        m_reply = 1;
        m_reply_byte = b;
        m_op = 0;
    endtask

    task automatic model_frame_check();
        int need;
        logic [7:0] x;
        if (m_frame[0] != 8'h57 && m_frame[0] != 8'h52) begin
            model_reply(8'h15);
            m_frame.delete();
            return;
        end
        need = ((m_frame[0] == 8'h57) ? 3 : 2) + CS;
        if (m_frame.size() < need) return;
        x = 8'h00;
        for (int i = 0; i < need - 1; i++) x = x ^ m_frame[i];
        if (CS != 0 && x != m_frame[need-1]) begin
            model_reply(8'h15);
        end else begin
            m_op = 1;
            m_granted = 0;
            m_we = (m_frame[0] == 8'h57);
            m_addr = m_frame[1] & 8'((1 << AW) - 1);
            if (m_we) m_wdata = m_frame[2];
        end
        m_frame.delete();
    endtask

    task automatic model_step();
        if (rst_i) begin
            m_frame.delete();
            m_idle = 0; m_op = 0; m_granted = 0; m_reply = 0; m_ovr = 0;
            m_rst_seen = 1;
            return;
        end
        m_rst_seen = 0;
        if ((m_op || m_reply) && rx_valid_i) m_ovr = 1;
        if (m_reply) begin
            if (tx_ready_i) begin
                m_reply = 0;
                $display("TXN response byte %02h sent", m_reply_byte);
            end
        end else if (m_op) begin
            if (!m_granted) begin
                if (bus_gnt_i) begin
                    if (m_we) model_reply(8'h06);
                    else if (bus_rvalid_i) model_reply(bus_rdata_i);
                    else m_granted = 1;
                end
            end else if (bus_rvalid_i) begin
                model_reply(bus_rdata_i);
            end
        end else if (!en_i) begin
            m_frame.delete();
        end else if (rx_valid_i) begin
            m_frame.push_back(rx_data_i);
            m_idle = 0;
            model_frame_check();
        end else if (m_frame.size() > 0) begin
            m_idle++;
            if (m_idle >= TO) m_frame.delete();
        end
    endtask

    task automatic compare();
        chk("overrun", overrun_o, m_ovr);
        chk("bus_req", bus_req_o, m_op && !m_granted);
        chk("tx_valid", tx_valid_o, m_reply);
        if (m_op && !m_granted) begin
            chk("bus_we", bus_we_o, m_we);
            chk("bus_addr", bus_addr_o, m_addr[AW-1:0]);
            if (m_we) chk("bus_wdata", bus_wdata_o, m_wdata);
        end
        if (m_reply) chk("tx_data", tx_data_o, m_reply_byte);
        if (m_rst_seen) begin
            chk("rst_we", bus_we_o, 0);
            chk("rst_addr", bus_addr_o, 0);
            chk("rst_wdata", bus_wdata_o, 0);
            chk("rst_txdata", tx_data_o, 0);
        end
    endtask

    task automatic cycle();
        if (!man) begin
            bus_gnt_i = (m_op && !m_granted) && ($urandom_range(0, 99) < 40);
            if (m_op && !m_we && (m_granted || bus_gnt_i))
                bus_rvalid_i = ($urandom_range(0, 99) < 40);
            else
                bus_rvalid_i = ($urandom_range(0, 19) == 0);
            bus_rdata_i = 8'($urandom);
            tx_ready_i = ($urandom_range(0, 99) < 50);
        end
        @(posedge clk);
        model_step();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i = b;
        cycle();
        rx_valid_i = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
        send(c);
        send(a);
        if (c == 8'h57) send(d);
        if (CS != 0) send(c ^ a ^ ((c == 8'h57) ? d : 8'h00));
    endtask

    logic [7:0] gen_q[$];
    int gap = 0;

    task automatic build_frame();
        logic [7:0] c, a, d, x;
        if ($urandom_range(0, 9) == 0) begin
            gen_q.push_back(8'($urandom));
            return;
        end
        c = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
        a = 8'($urandom);
        d = 8'($urandom);
        gen_q.push_back(c);
        gen_q.push_back(a);
        if (c == 8'h57) gen_q.push_back(d);
        if (CS != 0) begin
            x = c ^ a ^ ((c == 8'h57) ? d : 8'h00);
            if ($urandom_range(0, 7) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            gen_q.push_back(x);
        end
    endtask

    initial begin
        // Reset
        cycle();
        cycle();
        rst_i = 1'b0;
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_overrun", overrun_o, 0);

        // Write 57,10,A5; grant after 3 cycles
        send_cmd(8'h57, 8'h10, 8'hA5);
        chk("wr_req", bus_req_o, 1);
        chk("wr_we", bus_we_o, 1);
        chk("wr_addr", bus_addr_o, 6'h10);
        chk("wr_wdata", bus_wdata_o, 8'hA5);
        repeat (3) cycle();
        chk("wr_req_held", bus_req_o, 1);
        bus_gnt_i = 1'b1; cycle(); bus_gnt_i = 1'b0;
        chk("wr_ack_valid", tx_valid_o, 1);
        chk("wr_ack_data", tx_data_o, 8'h06);
        chk("wr_req_drop", bus_req_o, 0);
        tx_ready_i = 1'b1; cycle(); tx_ready_i = 1'b0;
        chk("wr_ack_once", tx_valid_o, 0);

        // Read 52,3C; grant, rvalid later, tx held while not ready
        send_cmd(8'h52, 8'h3C, 8'h00);
        chk("rd_req", bus_req_o, 1);
        chk("rd_we", bus_we_o, 0);
        chk("rd_addr", bus_addr_o, 6'h3C);
        bus_gnt_i = 1'b1; cycle(); bus_gnt_i = 1'b0;
        chk("rd_wait_noreq", bus_req_o, 0);
        repeat (3) cycle();
        chk("rd_wait_notx", tx_valid_o, 0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 8'hC3; cycle(); bus_rvalid_i = 1'b0; bus_rdata_i = 8'h00;
        for (int i = 0; i < 10; i++) begin
            chk("rd_hold_valid", tx_valid_o, 1);
            chk("rd_hold_data", tx_data_o, 8'hC3);
            cycle();
        end
        tx_ready_i = 1'b1; cycle(); tx_ready_i = 1'b0;
        chk("rd_done", tx_valid_o, 0);

        // Bad command, then a normal read
        send(8'h41);
        chk("bad_valid", tx_valid_o, 1);
        chk("bad_nak", tx_data_o, 8'h15);
        chk("bad_noreq", bus_req_o, 0);
        tx_ready_i = 1'b1; cycle(); tx_ready_i = 1'b0;
        send_cmd(8'h52, 8'h01, 8'h00);
        chk("bad_then_rd", bus_addr_o, 6'h01);
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 8'h77; cycle();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        chk("same_cyc_rdata", tx_data_o, 8'h77);
        tx_ready_i = 1'b1; cycle(); tx_ready_i = 1'b0;

        // Timeout: partial write dropped after TO idle cycles
        send(8'h57); send(8'h20);
        repeat (TO) cycle();
        send_cmd(8'h52, 8'h20, 8'h00);
        chk("to_req", bus_req_o, 1);
        chk("to_is_read", bus_we_o, 0);
        chk("to_addr", bus_addr_o, 6'h20);
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 8'h5A; cycle();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        tx_ready_i = 1'b1; cycle(); tx_ready_i = 1'b0;

        // Overrun during BUS, write still acknowledged
        send_cmd(8'h57, 8'h01, 8'h02);
        send(8'hFF);
        chk("ovr_set", overrun_o, 1);
        chk("ovr_req_kept", bus_req_o, 1);
        chk("ovr_wdata", bus_wdata_o, 8'h02);
        bus_gnt_i = 1'b1; cycle(); bus_gnt_i = 1'b0;
        chk("ovr_ack", tx_data_o, 8'h06);
        tx_ready_i = 1'b1; cycle(); tx_ready_i = 1'b0;

        // Reset while waiting for read data
        send_cmd(8'h52, 8'h05, 8'h00);
        bus_gnt_i = 1'b1; cycle(); bus_gnt_i = 1'b0;
        rst_i = 1'b1; cycle(); rst_i = 1'b0;
        chk("rst_rw_req", bus_req_o, 0);
        chk("rst_rw_ovr", overrun_o, 0);
        chk("rst_rw_addr", bus_addr_o, 0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 8'h99; cycle(); bus_rvalid_i = 1'b0;
        chk("rst_rw_notx", tx_valid_o, 0);

        if (CS != 0) begin
            send(8'h57); send(8'h10); send(8'hA5); send(8'h00);
            chk("cs_nak_valid", tx_valid_o, 1);
            chk("cs_nak_data", tx_data_o, 8'h15);
            chk("cs_nak_noreq", bus_req_o, 0);
            tx_ready_i = 1'b1; cycle(); tx_ready_i = 1'b0;
            send(8'h57); send(8'h10); send(8'hA5); send(8'hE2);
            chk("cs_ok_req", bus_req_o, 1);
            bus_gnt_i = 1'b1; cycle(); bus_gnt_i = 1'b0;
            chk("cs_ok_ack", tx_data_o, 8'h06);
            tx_ready_i = 1'b1; cycle(); tx_ready_i = 1'b0;
        end

        // Random traffic
        man = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            rst_i = ($urandom_range(0, 799) == 0);
            en_i = ($urandom_range(0, 49) != 0);
            rx_valid_i = 1'b0;
            if (gap > 0) begin
                gap--;
            end else begin
                if (gen_q.size() == 0) build_frame();
                rx_valid_i = 1'b1;
                rx_data_i = gen_q.pop_front();
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5, 6: gap = $urandom_range(0, 3);
                    7, 8:                gap = $urandom_range(4, 12);
                    default:             gap = $urandom_range(TO - 2, TO + 4);
                endcase
            end
            cycle();
        end
        rx_valid_i = 1'b0;
        rst_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
